// File: rtl/forti_audio_pkg.sv
`default_nettype none
// ============================================================================
// forti_audio_pkg : shared constants and mix helper for the FORTi audio path
// Revision 1.0
// ============================================================================
package forti_audio_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int PCM_BITS   = 16;
  localparam int MIX_BITS   = 10;
  localparam int VOICES     = 4;

  localparam logic [MIX_BITS-1:0] MIX_MIDPOINT     = 10'd512;
  localparam logic [23:0]         DEFAULT_BCLK_INC = 24'd473520;
  localparam logic [PCM_BITS-1:0] PCM_RESET        = 16'h8000;

  typedef logic [VOICES-1:0][7:0] voice_bus_t;

  // Centre the unsigned mix on zero and scale it up to a 16-bit signed word.
  function automatic logic [PCM_BITS-1:0] mix_to_pcm(input logic [MIX_BITS-1:0] sum,
                                                     input int unsigned          shift);
    logic [MIX_BITS:0] centred;
    centred = {1'b0, sum} - {1'b0, MIX_MIDPOINT};
    return {{(PCM_BITS-MIX_BITS-1){centred[MIX_BITS]}}, centred} << shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_serializer.sv
`default_nettype none
// ============================================================================
// i2s_serializer : 64-bit I2S frame sequencer, same word in both slots
// Revision 1.0
// ============================================================================
module i2s_serializer
  import forti_audio_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [PCM_BITS-1:0] pcm_in,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                load
);

  localparam int CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_W = $clog2(SLOT_BITS);

  logic [CNT_W-1:0]    bitcnt;
  logic [CNT_W-1:0]    bitcnt_next;
  logic [SLOT_W-1:0]   slot_pos;
  logic [PCM_BITS-1:0] word_hold;
  logic [PCM_BITS-1:0] shreg;
  logic                fall;

  assign fall        = tick & bclk;
  assign bitcnt_next = bitcnt + 1'b1;
  assign slot_pos    = bitcnt_next[SLOT_W-1:0];
  assign load        = fall && (bitcnt_next == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      bitcnt    <= '0;
      word_hold <= PCM_RESET;
      shreg     <= PCM_RESET;
    end else begin
      if (tick) begin
        bclk <= ~bclk;
      end
      if (fall) begin
        bitcnt <= bitcnt_next;
        lrclk  <= bitcnt_next[CNT_W-1];
        // Slot position 0 is the one-bit I2S delay; the shifter is primed here.
        if (slot_pos == '0) begin
          sdata <= 1'b0;
          if (load) begin
            word_hold <= pcm_in;
            shreg     <= pcm_in;
          end else begin
            shreg <= word_hold;
          end
        end else if (slot_pos <= SLOT_W'(PCM_BITS)) begin
          sdata <= shreg[PCM_BITS-1];
          shreg <= {shreg[PCM_BITS-2:0], 1'b0};
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/forti_audio_out.sv
`default_nettype none
// ============================================================================
// forti_audio_out : four-voice mixer, sndclk->clk capture filter, I2S output
// Revision 1.0
// ============================================================================
module forti_audio_out
  import forti_audio_pkg::*;
#(
  parameter int                   ACC_WIDTH  = 24,
  parameter logic [ACC_WIDTH-1:0] BCLK_INC   = ACC_WIDTH'(DEFAULT_BCLK_INC),
  parameter int                   GAIN_SHIFT = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          sample1,
  input  logic [7:0]          sample2,
  input  logic [7:0]          sample3,
  input  logic [7:0]          sample4,
  input  logic [VOICES-1:0]   mute,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic [PCM_BITS-1:0] pcm,
  output logic                frame_strobe
);

  voice_bus_t          voices_a;
  voice_bus_t          voices_b;
  voice_bus_t          voices_stable;
  logic [MIX_BITS-1:0] mix_sum;
  logic [PCM_BITS-1:0] word;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]  acc_sum;
  logic                tick;
  logic                load;

  // Two back-to-back captures must agree before a multi-bit sample is trusted.
  always_ff @(posedge clk) begin
    if (reset) begin
      voices_a      <= '0;
      voices_b      <= '0;
      voices_stable <= '0;
    end else begin
      voices_a <= {sample4, sample3, sample2, sample1};
      voices_b <= voices_a;
      if (voices_a == voices_b) begin
        voices_stable <= voices_b;
      end
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < VOICES; v++) begin
      mix_sum = mix_sum + (mute[v] ? '0 : {2'b00, voices_stable[v]});
    end
    word = mix_to_pcm(mix_sum, GAIN_SHIFT);
  end

  assign acc_sum = {1'b0, acc} + {1'b0, BCLK_INC};
  assign tick    = acc_sum[ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      pcm          <= PCM_RESET;
      frame_strobe <= 1'b0;
    end else begin
      acc          <= acc_sum[ACC_WIDTH-1:0];
      frame_strobe <= load;
      if (load) begin
        pcm <= word;
      end
    end
  end

  i2s_serializer u_serializer (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .pcm_in (word),
    .bclk   (bclk),
    .lrclk  (lrclk),
    .sdata  (sdata),
    .load   (load)
  );

endmodule
`default_nettype wire

// File: tb/tb_forti_audio_out.sv
`default_nettype none
// ============================================================================
// tb_forti_audio_out : randomized self-checking bench with closed-form I2S model
// Revision 1.0
// ============================================================================
module tb_forti_audio_out;

  localparam longint INC      = 473520;
  localparam real    CLK_NS   = 10.0;
  localparam real    FRAME_NS = 128.0 * 16777216.0 / 473520.0 * CLK_NS;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sample1, sample2, sample3, sample4;
  logic [3:0]  mute;
  logic        bclk, lrclk, sdata, frame_strobe;
  logic [15:0] pcm;

  int checks   = 0;
  int failures = 0;

  // Bench-side reference state
  longint      n_edges;
  longint      ticks_prev;
  int          model_pos = 0;
  logic [15:0] exp_pcm;
  bit          pcm_known   = 1'b1;
  bit          sdata_known = 1'b0;
  bit          unstable    = 1'b0;
  bit          toggling    = 1'b0;
  int          toggle_cnt  = 0;
  real         last_strobe_t;
  real         last_lr_t   = -1.0;
  logic        lr_prev     = 1'b0;

  forti_audio_out dut (
    .clk          (clk),
    .reset        (reset),
    .sample1      (sample1),
    .sample2      (sample2),
    .sample3      (sample3),
    .sample4      (sample4),
    .mute         (mute),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .pcm          (pcm),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Word the DAC should receive for given voice levels and mutes.
  function automatic logic [15:0] model_word(input logic [7:0] s1, input logic [7:0] s2,
                                             input logic [7:0] s3, input logic [7:0] s4,
                                             input logic [3:0] m);
    int sum;
    sum = (m[0] ? 0 : int'(s1)) + (m[1] ? 0 : int'(s2)) +
          (m[2] ? 0 : int'(s3)) + (m[3] ? 0 : int'(s4));
    return 16'((sum - 512) * 64);
  endfunction

  function automatic bit near(input real a, input real b);
    return (a - b <= 20.0) && (b - a <= 20.0);
  endfunction

  // Outputs are sampled 1 ns after each rising edge and compared with a model
  // built from elapsed clock count: ticks = floor(n*INC / 2^24).
  always @(posedge clk) begin
    #1;
    if (reset) begin
      n_edges    = 0;
      ticks_prev = 0;
      model_pos  = 0;
      check_value("rst_bclk",   32'(bclk),         32'd0);
      check_value("rst_lrclk",  32'(lrclk),        32'd0);
      check_value("rst_sdata",  32'(sdata),        32'd0);
      check_value("rst_pcm",    32'(pcm),          32'h8000);
      check_value("rst_strobe", 32'(frame_strobe), 32'd0);
      exp_pcm       = 16'h8000;
      pcm_known     = 1'b1;
      sdata_known   = 1'b0;
      last_strobe_t = $realtime;
      last_lr_t     = -1.0;
      lr_prev       = 1'b0;
    end else begin
      longint ticks_now;
      bit     fall_now, exp_strobe;
      int     p;
      logic   exp_sd;
      n_edges++;
      ticks_now  = (n_edges * INC) >> 24;
      fall_now   = (ticks_now != ticks_prev) && (ticks_now[0] == 1'b0);
      model_pos  = int'((ticks_now >> 1) % 64);
      exp_strobe = fall_now && (model_pos == 0);
      ticks_prev = ticks_now;

      check_value("bclk",   32'(bclk),         32'(ticks_now[0]));
      check_value("lrclk",  32'(lrclk),        32'(model_pos >= 32));
      check_value("strobe", 32'(frame_strobe), 32'(exp_strobe));

      if (exp_strobe) begin
        check_value("strobe_gap", 32'(near($realtime - last_strobe_t, FRAME_NS)), 32'd1);
        last_strobe_t = $realtime;
        if (unstable) begin
          check_value("unstable_pcm",
                      32'((pcm == model_word(8'h00, sample2, sample3, sample4, mute)) ||
                          (pcm == model_word(8'hFF, sample2, sample3, sample4, mute))), 32'd1);
          pcm_known   = 1'b0;
          sdata_known = 1'b0;
        end else begin
          exp_pcm     = model_word(sample1, sample2, sample3, sample4, mute);
          pcm_known   = 1'b1;
          sdata_known = 1'b1;
        end
      end

      if (pcm_known) begin
        check_value("pcm", 32'(pcm), 32'(exp_pcm));
      end
      if (sdata_known) begin
        p      = model_pos % 32;
        exp_sd = (p >= 1 && p <= 16) ? exp_pcm[16-p] : 1'b0;
        check_value("sdata", 32'(sdata), 32'(exp_sd));
      end

      if (lrclk && !lr_prev) begin
        if (last_lr_t >= 0.0) begin
          check_value("lr_period", 32'(near($realtime - last_lr_t, FRAME_NS)), 32'd1);
        end
        last_lr_t = $realtime;
      end
      lr_prev = lrclk;
    end
  end

  task automatic wait_strobe();
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (toggling) begin
        toggle_cnt++;
        if (toggle_cnt == 3) begin
          toggle_cnt = 0;
          sample1    = ~sample1;
        end
      end
      if (frame_strobe) return;
    end
    check_value("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input int target);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (model_pos == target) return;
    end
    check_value("pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_voices(input logic [7:0] s1, input logic [7:0] s2,
                            input logic [7:0] s3, input logic [7:0] s4, input logic [3:0] m);
    sample1 = s1;
    sample2 = s2;
    sample3 = s3;
    sample4 = s4;
    mute    = m;
  endtask

  initial begin
    reset = 1'b1;
    set_voices(8'h80, 8'h80, 8'h80, 8'h80, 4'b0000);
    repeat (5) @(negedge clk);
    reset = 1'b0;

    wait_strobe();                                            // midpoint -> 0x0000
    set_voices(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    wait_strobe();                                            // full negative -> 0x8000
    set_voices(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000);
    wait_strobe();                                            // full positive -> 0x7F00
    mute = 4'b0101;
    wait_strobe();                                            // 510 -> 0xFF80
    wait_strobe();

    for (int r = 0; r < 3; r++) begin
      set_voices(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)));
      wait_strobe();
    end

    set_voices(8'h00, 8'h80, 8'h80, 8'h80, 4'b0000);
    toggle_cnt = 0;
    toggling   = 1'b1;
    unstable   = 1'b1;
    wait_strobe();
    wait_strobe();
    toggling = 1'b0;
    unstable = 1'b0;
    sample1  = 8'h40;
    wait_strobe();

    wait_pos(40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_strobe();
    wait_strobe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
